cdb_arbiter: RTL
================

// Module: cdb_arbiter
// PURPOSE
//  Shares the NUM_BUS result buses (common data buses) among NUM_REQ execution-unit requesters
//  (ALU, branch, load/store, mul/div). Each cycle it grants up to NUM_BUS requesters in
//  round-robin order and registers their results onto the buses, one cycle later. The buses
//  feed the ROB, the reservation stations and the register file. Tagged (speculative) results
//  are suppressed when the ROB issues delete_tagged; they are untagged on clear_tags.
// PARAMETERS
//  XLEN      32  result data width
//  NUM_REQ   4   number of requesting units (>=2)
//  NUM_BUS   2   number of result buses (1..NUM_REQ)
//  RRN_W     6   renamed-register index width
//  ARN_W     5   architectural-register index width
// PORTS
//  clk            in   1                clock
//  reset          in   1                synchronous, active-high
//  delete_tagged  in   1                ROB flush of speculative (tag=1) work
//  clear_tags     in   1                ROB: speculation resolved, clear tag bits
//  req            in   NUM_REQ          requester i has a result pending
//  req_data       in   NUM_REQ*XLEN     result value, per requester
//  req_rrn        in   NUM_REQ*RRN_W    destination renamed reg, per requester
//  req_arn        in   NUM_REQ*ARN_W    destination arch reg, per requester
//  req_tag        in   NUM_REQ          speculative flag, per requester
//  gnt            out  NUM_REQ          requester i is accepted this cycle (combinational)
//  bus_valid      out  NUM_BUS          bus k carries a result
//  bus_data       out  NUM_BUS*XLEN     bus k value
//  bus_rrn        out  NUM_BUS*RRN_W    bus k renamed reg
//  bus_arn        out  NUM_BUS*ARN_W    bus k arch reg
//  bus_tag        out  NUM_BUS          bus k speculative flag
// BEHAVIOUR
//  - Reset (sync): bus_valid/data/rrn/arn/tag <= 0, rr_ptr <= 0. gnt=0 in any cycle where reset=1.
//  - Handshake: a requester holds req and its payload stable until it samples gnt=1 at a clock
//    edge. Transfer happens on that edge. gnt never asserts without req.
//  - Eligible(i) = req[i] && !(delete_tagged && req_tag[i]).
//  - Scan order: rr_ptr, rr_ptr+1, ... mod NUM_REQ. The first eligible requester goes to bus 0,
//    the second to bus 1, and so on, up to NUM_BUS. #gnt = min(#eligible, NUM_BUS).
//  - Latency: a payload granted in cycle n appears on its bus in cycle n+1, with bus_valid=1.
//    Buses with no winner have bus_valid <= 0; their data fields are don't-care but hold their
//    values. The buses reload every cycle; there is no downstream backpressure.
//  - bus_tag <= req_tag & ~clear_tags for the winner. clear_tags in cycle n also clears bus_tag
//    of values already registered: bus_tag <= 0 on all buses at the edge ending cycle n.
//  - delete_tagged in cycle n: no tagged request is granted. Every bus currently holding
//    bus_tag=1 is not re-presented (reloaded anyway). delete_tagged and clear_tags together:
//    delete_tagged wins for requests, and clear_tags applies to the surviving winners.
//  - rr_ptr: if any grant, rr_ptr <= (index of last-granted requester + 1) mod NUM_REQ.
//    Otherwise it is unchanged. Wrap-around: a grant of index NUM_REQ-1 gives rr_ptr=0.
//  - Fairness: a continuously eligible requester is granted within ceil(NUM_REQ/NUM_BUS) cycles.
//  - Reset mid-operation: pending requests are not granted. Requesters are reset by the same
//    signal. Outputs are zero the cycle after reset.
//  - Widths: rr_ptr is $clog2(NUM_REQ) bits. Index arithmetic uses mod NUM_REQ, which is also
//    correct for non-power-of-2 values.
// TESTING
//  1 reset=1 for 2 cycles with req=4'b1111 -> gnt=0 throughout; after reset bus_valid=2'b00, rr_ptr=0.
//  2 rr_ptr=0, req=4'b1111, data i=0x10+i, held until granted -> cyc0 gnt=0011; cyc1 bus0=0x10,
//    bus1=0x11, gnt=1100; cyc2 bus0=0x12, bus1=0x13, rr_ptr=0.
//  3 rr_ptr=0, req=4'b1000, data=0xDEAD -> gnt=1000; next cycle bus_valid=01, bus0=0xDEAD, rr_ptr=0 (wrap).
//  4 delete_tagged=1, req=0111, tag=0101 -> gnt=0010; next cycle bus_valid=01, bus0 from req1, bus_tag=0.
//  5 req0 tag=1 granted with clear_tags=1 -> bus_tag[0]=0 next cycle. A bus holding tag=1 is
//    followed by clear_tags with no grants -> bus_tag=0, bus_valid=0.
//  6 random req/tag/flush for 10k cycles -> scoreboard: each payload appears exactly once in order
//    of grant, no untagged loss, no requester waits >2 cycles while eligible.

Source files
------------

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: shares NUM_BUS result buses among NUM_REQ execution units.
//
// Each cycle up to NUM_BUS requesters are granted in round-robin order.
// Their results are registered onto the buses one cycle later.
//
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   delete_tagged  flush of speculative (tag=1) work
//   clear_tags     speculation resolved: clear tag bits
//   req*           per-requester valid, data, rrn, arn, tag
//   gnt            per-requester accept (combinational)
//   bus_*          per-bus valid, data, rrn, arn, tag (registered)
module cdb_arbiter #(
    parameter int XLEN    = 32,
    parameter int NUM_REQ = 4,
    parameter int NUM_BUS = 2,
    parameter int RRN_W   = 6,
    parameter int ARN_W   = 5
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       delete_tagged,
    input  logic                       clear_tags,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*XLEN-1:0]    req_data,
    input  logic [NUM_REQ*RRN_W-1:0]   req_rrn,
    input  logic [NUM_REQ*ARN_W-1:0]   req_arn,
    input  logic [NUM_REQ-1:0]         req_tag,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [NUM_BUS-1:0]         bus_valid,
    output logic [NUM_BUS*XLEN-1:0]    bus_data,
    output logic [NUM_BUS*RRN_W-1:0]   bus_rrn,
    output logic [NUM_BUS*ARN_W-1:0]   bus_arn,
    output logic [NUM_BUS-1:0]         bus_tag
);

    localparam int PTR_W = $clog2(NUM_REQ);

    logic [PTR_W-1:0]         rr_ptr_q;
    logic [PTR_W-1:0]         rr_ptr_d;
    logic [NUM_BUS-1:0]       bus_valid_q;
    logic [NUM_BUS-1:0]       bus_valid_d;
    logic [NUM_BUS*XLEN-1:0]  bus_data_q;
    logic [NUM_BUS*XLEN-1:0]  bus_data_d;
    logic [NUM_BUS*RRN_W-1:0] bus_rrn_q;
    logic [NUM_BUS*RRN_W-1:0] bus_rrn_d;
    logic [NUM_BUS*ARN_W-1:0] bus_arn_q;
    logic [NUM_BUS*ARN_W-1:0] bus_arn_d;
    logic [NUM_BUS-1:0]       bus_tag_q;
    logic [NUM_BUS-1:0]       bus_tag_d;

    logic [NUM_REQ-1:0]       elig;
    logic [NUM_REQ-1:0]       gnt_c;
    logic [NUM_BUS-1:0]       win_vld;
    logic [PTR_W-1:0]         win_idx [NUM_BUS];
    logic [PTR_W-1:0]         last_idx;

    // A flush blocks tagged requests in the same cycle.
    assign elig = req & ~({NUM_REQ{delete_tagged}} & req_tag);

    // Round-robin scan starting at rr_ptr; the n-th eligible
    // requester found is routed to bus n.
    always_comb begin
        int cnt;
        int idx;
        gnt_c    = '0;
        win_vld  = '0;
        last_idx = rr_ptr_q;
        cnt      = 0;
        for (int k = 0; k < NUM_BUS; k++) begin
            win_idx[k] = '0;
        end
        for (int j = 0; j < NUM_REQ; j++) begin
            idx = int'(rr_ptr_q) + j;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (elig[idx] && cnt < NUM_BUS) begin
                gnt_c[idx]   = 1'b1;
                win_vld[cnt] = 1'b1;
                win_idx[cnt] = PTR_W'(idx);
                last_idx     = PTR_W'(idx);
                cnt          = cnt + 1;
            end
        end
        if (reset) begin
            gnt_c   = '0;
            win_vld = '0;
        end
    end

    // Pointer moves just past the last winner, wrapping mod NUM_REQ.
    always_comb begin
        int nxt;
        rr_ptr_d = rr_ptr_q;
        nxt      = int'(last_idx) + 1;
        if (nxt >= NUM_REQ) begin
            nxt = 0;
        end
        if (|gnt_c) begin
            rr_ptr_d = PTR_W'(nxt);
        end
    end

    // Buses reload every cycle. Idle buses drop valid and keep their
    // payload; clear_tags also strips the tag of any held value.
    always_comb begin
        int src;
        bus_valid_d = '0;
        bus_data_d  = bus_data_q;
        bus_rrn_d   = bus_rrn_q;
        bus_arn_d   = bus_arn_q;
        bus_tag_d   = bus_tag_q & ~{NUM_BUS{clear_tags}};
        for (int k = 0; k < NUM_BUS; k++) begin
            src = int'(win_idx[k]);
            if (win_vld[k]) begin
                bus_valid_d[k] = 1'b1;
                bus_data_d[k*XLEN +: XLEN] =
                    req_data[src*XLEN +: XLEN];
                bus_rrn_d[k*RRN_W +: RRN_W] =
                    req_rrn[src*RRN_W +: RRN_W];
                bus_arn_d[k*ARN_W +: ARN_W] =
                    req_arn[src*ARN_W +: ARN_W];
                bus_tag_d[k] = req_tag[src] & ~clear_tags;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_q    <= '0;
            bus_valid_q <= '0;
            bus_data_q  <= '0;
            bus_rrn_q   <= '0;
            bus_arn_q   <= '0;
            bus_tag_q   <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            bus_valid_q <= bus_valid_d;
            bus_data_q  <= bus_data_d;
            bus_rrn_q   <= bus_rrn_d;
            bus_arn_q   <= bus_arn_d;
            bus_tag_q   <= bus_tag_d;
        end
    end

    assign gnt       = gnt_c;
    assign bus_valid = bus_valid_q;
    assign bus_data  = bus_data_q;
    assign bus_rrn   = bus_rrn_q;
    assign bus_arn   = bus_arn_q;
    assign bus_tag   = bus_tag_q;

endmodule
